lpif_ustrm_half_flit_packer: RTL



---
 rtl/lpif_ustrm_half_flit_packer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lpif_ustrm_half_flit_packer.sv
// Packs 256-bit user half-flits into 512-bit LPIF ustrm beats for the x8 asym1 half-rate slave.
// Lone halves are flushed on protocol-ID change, in_last, idle timeout or link drop.
module lpif_ustrm_half_flit_packer #(
  parameter int unsigned HALF_W        = 256,
  parameter int unsigned PROTID_W      = 4,
  parameter logic [7:0]  ACTIVE_STATE  = 8'h01,
  parameter logic [7:0]  RESET_STATE   = 8'h00,
  parameter logic [15:0] FLUSH_TIMEOUT = 16'd64
) (
  input  logic                  clk_wr,
  input  logic                  rst_wr,
  input  logic                  tx_online,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [HALF_W-1:0]     in_data,
  input  logic [PROTID_W-1:0]   in_protid,
  input  logic                  in_last,
  output logic [7:0]            ustrm_state,
  output logic [PROTID_W-1:0]   ustrm_protid,
  output logic [2*HALF_W-1:0]   ustrm_data,
  output logic [1:0]            ustrm_dvalid,
  output logic [15:0]           ustrm_crc,
  output logic [1:0]            ustrm_crc_valid,
  output logic [1:0]            ustrm_valid,
  output logic [15:0]           beat_count
);

  // state    | meaning
  // S_RESET  | link offline, no input accepted, ustrm_state = RESET_STATE
  // S_ACTIVE | accepting and packing half-flits
  // S_DRAIN  | link dropped; flush a held half (if any) then return to S_RESET
  typedef enum logic [1:0] {S_RESET, S_ACTIVE, S_DRAIN} state_t;

  state_t                r_state;
  logic                  r_hold_vld;
  logic [HALF_W-1:0]     r_hold_data;
  logic [PROTID_W-1:0]   r_hold_protid;
  logic [15:0]           r_idle;
  logic [7:0]            r_ustrm_state;
  logic [PROTID_W-1:0]   r_ustrm_protid;
  logic [2*HALF_W-1:0]   r_ustrm_data;
  logic [1:0]            r_ustrm_dvalid;
  logic [15:0]           r_beat_count;

  logic                  w_mismatch;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_timeout;
  logic                  w_emit;
  logic [2*HALF_W-1:0]   w_emit_data;
  logic [PROTID_W-1:0]   w_emit_protid;
  logic [1:0]            w_emit_dvalid;

  // A different protid cannot join the held half, so the input stalls while the holder flushes.
  assign w_mismatch = r_hold_vld && (in_protid != r_hold_protid);
  assign w_ready    = (r_state == S_ACTIVE) && !w_mismatch;
  assign w_accept   = in_valid && w_ready;
  assign w_timeout  = (FLUSH_TIMEOUT != 16'd0) && (r_idle == FLUSH_TIMEOUT - 16'd1);

  always_comb begin
    w_emit        = 1'b0;
    w_emit_data   = {{HALF_W{1'b0}}, r_hold_data};
    w_emit_protid = r_hold_protid;
    w_emit_dvalid = 2'b01;
    case (r_state)
      S_ACTIVE: begin
        if (w_accept && r_hold_vld) begin
          w_emit        = 1'b1;
          w_emit_data   = {in_data, r_hold_data};
          w_emit_dvalid = 2'b11;
        end else if (w_accept && in_last) begin
          w_emit        = 1'b1;
          w_emit_data   = {{HALF_W{1'b0}}, in_data};
          w_emit_protid = in_protid;
        end else if (r_hold_vld && !w_accept && (in_valid || w_timeout)) begin
          w_emit = 1'b1;
        end
      end
      S_DRAIN: w_emit = r_hold_vld;
      default: ;
    endcase
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      r_state        <= S_RESET;
      r_hold_vld     <= 1'b0;
      r_hold_data    <= '0;
      r_hold_protid  <= '0;
      r_idle         <= '0;
      r_ustrm_state  <= RESET_STATE;
      r_ustrm_protid <= '0;
      r_ustrm_data   <= '0;
      r_ustrm_dvalid <= 2'b00;
      r_beat_count   <= '0;
    end else begin
      r_ustrm_dvalid <= w_emit ? w_emit_dvalid : 2'b00;
      if (w_emit) begin
        r_ustrm_data   <= w_emit_data;
        r_ustrm_protid <= w_emit_protid;
        r_beat_count   <= r_beat_count + 16'd1;
      end
      if (w_accept && !r_hold_vld && !in_last) begin
        r_hold_vld    <= 1'b1;
        r_hold_data   <= in_data;
        r_hold_protid <= in_protid;
      end else if (w_emit) begin
        r_hold_vld <= 1'b0;
      end
      if (w_accept || w_emit)
        r_idle <= '0;
      else if (r_hold_vld && r_state == S_ACTIVE)
        r_idle <= r_idle + 16'd1;
      case (r_state)
        S_RESET: if (tx_online) begin
          r_state       <= S_ACTIVE;
          r_ustrm_state <= ACTIVE_STATE;
        end
        S_ACTIVE: if (!tx_online) r_state <= S_DRAIN;
        S_DRAIN: begin
          r_state       <= S_RESET;
          r_ustrm_state <= RESET_STATE;
        end
        default: r_state <= S_RESET;
      endcase
    end
  end

  assign in_ready        = w_ready;
  assign ustrm_state     = r_ustrm_state;
  assign ustrm_protid    = r_ustrm_protid;
  assign ustrm_data      = r_ustrm_data;
  assign ustrm_dvalid    = r_ustrm_dvalid;
  assign ustrm_valid     = r_ustrm_dvalid;
  assign ustrm_crc       = 16'h0000;
  assign ustrm_crc_valid = 2'b00;
  assign beat_count      = r_beat_count;

endmodule
